mem_access_stage: RTL and testbench

MEM-stage controller placed between the EX/MEM and MEM/WB pipeline registers. It issues loads and stores to a variable-latency data memory over a request/grant/response interface. While an access is outstanding it stalls the upstream pipeline and presents a bubble to MEM/WB. When the access completes it forwards the instruction's write-back controls, load data and ALU result for exactly one cycle.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_access_stage_sat_counter.sv | 28 ++
 rtl/mem_access_stage.sv | 133 +++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RESP = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam logic [31:0] WORD_ZERO  = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_access_stage_sat_counter.sv
// Enable-driven saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues loads/stores over req/gnt/rvalid, stalls upstream
// while an access is outstanding and hands one write-back to MEM/WB on completion.
//
// state   | meaning
// MS_IDLE | pass-through, or request issued and waiting for grant
// MS_RESP | read granted, waiting for rvalid
// MS_DONE | access complete, single write-back cycle to MEM/WB
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic                   MemtoReg_i,
  input  logic                   RegWrite_i,
  input  logic [31:0]            ALUoutput_i,
  input  logic [31:0]            wdata_i,
  input  logic [4:0]             reg_dst_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [31:0]            dmem_addr_o,
  output logic [31:0]            dmem_wdata_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [31:0]            dmem_rdata_i,
  output logic                   stall_o,
  output logic                   MemtoReg_o,
  output logic                   RegWrite_o,
  output logic [31:0]            dmem_rdata_o,
  output logic [31:0]            ALUoutput_o,
  output logic [4:0]             reg_dst_o,
  output logic                   addr_err_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  ms_state_e   state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic mem_op, is_write, misaligned;

  assign mem_op     = ex_valid_i & (MemRead_i | MemWrite_i);
  // Read wins when both controls are set.
  assign is_write   = MemWrite_i & ~MemRead_i;
  assign misaligned = mem_op & ((ALUoutput_i[1:0] & ALIGN_MASK) != 2'b00);

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = WORD_ZERO;
    dmem_wdata_o = WORD_ZERO;
    stall_o      = 1'b0;
    addr_err_o   = 1'b0;
    MemtoReg_o   = ex_valid_i & MemtoReg_i;
    RegWrite_o   = ex_valid_i & RegWrite_i;
    ALUoutput_o  = ALUoutput_i;
    reg_dst_o    = reg_dst_i;
    dmem_rdata_o = WORD_ZERO;

    unique case (state_q)
      MS_IDLE: begin
        if (misaligned) begin
          addr_err_o = 1'b1;
          MemtoReg_o = 1'b0;
          RegWrite_o = 1'b0;
        end else if (mem_op) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = is_write;
          dmem_addr_o  = ALUoutput_i;
          dmem_wdata_o = wdata_i;
          stall_o      = 1'b1;
          MemtoReg_o   = 1'b0;
          RegWrite_o   = 1'b0;
          if (dmem_gnt_i) state_d = is_write ? MS_DONE : MS_RESP;
        end
      end
      MS_RESP: begin
        stall_o    = 1'b1;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        if (dmem_rvalid_i) begin
          rdata_d = dmem_rdata_i;
          state_d = MS_DONE;
        end
      end
      MS_DONE: begin
        dmem_rdata_o = MemRead_i ? rdata_q : WORD_ZERO;
        state_d      = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase

    // Everything toward memory and MEM/WB is quiet while reset is held.
    if (!rst) begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = WORD_ZERO;
      dmem_wdata_o = WORD_ZERO;
      stall_o      = 1'b0;
      addr_err_o   = 1'b0;
      MemtoReg_o   = 1'b0;
      RegWrite_o   = 1'b0;
      ALUoutput_o  = WORD_ZERO;
      reg_dst_o    = 5'd0;
      dmem_rdata_o = WORD_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MS_IDLE;
      rdata_q <= WORD_ZERO;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst),
    .en_i (stall_o),
    .cnt_o(stall_cycles_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; a second instance with a 4-bit stall
// counter shares the stimulus to exercise saturation.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [31:0] alu, wdata;
  logic [4:0]  reg_dst;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        req, we, stall, m2r_o, rw_o, aerr;
  logic [31:0] addr, wdata_o, rdata_o, alu_o;
  logic [4:0]  rdst_o;
  logic [15:0] scnt;

  logic        req4, we4, stall4, m2r4, rw4, aerr4;
  logic [31:0] addr4, wdata4, rdata4, alu4;
  logic [4:0]  rdst4;
  logic [3:0]  scnt4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_access_stage u_dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .MemtoReg_i(mem_to_reg), .RegWrite_i(reg_write),
    .ALUoutput_i(alu), .wdata_i(wdata), .reg_dst_i(reg_dst),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata_o),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .stall_o(stall), .MemtoReg_o(m2r_o), .RegWrite_o(rw_o), .dmem_rdata_o(rdata_o),
    .ALUoutput_o(alu_o), .reg_dst_o(rdst_o), .addr_err_o(aerr), .stall_cycles_o(scnt)
  );

  mem_access_stage #(.STALL_CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .MemtoReg_i(mem_to_reg), .RegWrite_i(reg_write),
    .ALUoutput_i(alu), .wdata_i(wdata), .reg_dst_i(reg_dst),
    .dmem_req_o(req4), .dmem_we_o(we4), .dmem_addr_o(addr4), .dmem_wdata_o(wdata4),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .stall_o(stall4), .MemtoReg_o(m2r4), .RegWrite_o(rw4), .dmem_rdata_o(rdata4),
    .ALUoutput_o(alu4), .reg_dst_o(rdst4), .addr_err_o(aerr4), .stall_cycles_o(scnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    ex_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    alu = '0; wdata = '0; reg_dst = '0; gnt = 0; rvalid = 0; rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  stall_n, bad_wb, req_resp, req_hold;
    bit  done;

    clr_in();
    rst = 0;
    // Reset with an aligned load presented: nothing may leak out.
    ex_valid = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1; alu = 32'h100; reg_dst = 5'd7;
    #3;
    chk("rst_req",   32'(req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rw",    32'(rw_o), 0);
    chk("rst_addr",  addr, 0);
    chk("rst_alu_o", alu_o, 0);
    chk("rst_rdst",  32'(rdst_o), 0);
    chk("rst_scnt",  32'(scnt), 0);
    clr_in();
    step();
    rst = 1;
    #1;

    // R-type pass-through
    ex_valid = 1; reg_write = 1; alu = 32'h55; reg_dst = 5'd3;
    #1;
    chk("rtype_rw",    32'(rw_o), 1);
    chk("rtype_alu",   alu_o, 32'h55);
    chk("rtype_rdst",  32'(rdst_o), 3);
    chk("rtype_stall", 32'(stall), 0);
    chk("rtype_req",   32'(req), 0);
    chk("rtype_rdata", rdata_o, 0);
    ex_valid = 0;
    #1;
    chk("invalid_rw", 32'(rw_o), 0);
    step();

    // Store with immediate grant
    clr_in();
    ex_valid = 1; mem_write = 1; alu = 32'h100; wdata = 32'hDEADBEEF; gnt = 1;
    #1;
    chk("st_req",   32'(req), 1);
    chk("st_we",    32'(we), 1);
    chk("st_addr",  addr, 32'h100);
    chk("st_wdata", wdata_o, 32'hDEADBEEF);
    chk("st_stall", 32'(stall), 1);
    step();
    gnt = 0;
    #1;
    chk("st_done_req",   32'(req), 0);
    chk("st_done_stall", 32'(stall), 0);
    chk("st_done_rw",    32'(rw_o), 0);
    chk("st_done_rdata", rdata_o, 0);
    chk("st_scnt",       32'(scnt), 1);
    step();
    clr_in();

    // Load: grant after 2 cycles, rvalid 3 cycles after grant
    ex_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu = 32'h200; reg_dst = 5'd5;
    stall_n = 0; bad_wb = 0; req_resp = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      gnt    = (c == 2);
      rvalid = (c == 5);
      rdata  = (c == 5) ? 32'h12345678 : 32'h0;
      #1;
      if (stall) begin
        stall_n++;
        if (rw_o) bad_wb++;
        if (c >= 3 && req) req_resp++;
        step();
      end else begin
        done = 1;
      end
    end
    chk("ld_done_seen", 32'(done), 1);
    chk("ld_stall_n",   32'(stall_n), 6);
    chk("ld_bubble",    32'(bad_wb), 0);
    chk("ld_req_resp",  32'(req_resp), 0);
    chk("ld_rw",        32'(rw_o), 1);
    chk("ld_m2r",       32'(m2r_o), 1);
    chk("ld_rdata",     rdata_o, 32'h12345678);
    chk("ld_rdst",      32'(rdst_o), 5);
    chk("ld_scnt",      32'(scnt), 7);
    step();
    clr_in();

    // Misaligned load
    ex_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu = 32'h202; reg_dst = 5'd9;
    #1;
    chk("mis_aerr",  32'(aerr), 1);
    chk("mis_req",   32'(req), 0);
    chk("mis_rw",    32'(rw_o), 0);
    chk("mis_stall", 32'(stall), 0);
    step();
    clr_in();
    #1;
    chk("mis_aerr_off", 32'(aerr), 0);
    chk("mis_scnt",     32'(scnt), 7);

    // Reset while in RESP, then a stale rvalid
    ex_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu = 32'h300; reg_dst = 5'd4; gnt = 1;
    #1;
    step();
    gnt = 0;
    #1;
    chk("resp_stall", 32'(stall), 1);
    rst = 0;
    #1;
    chk("rstm_req",   32'(req), 0);
    chk("rstm_stall", 32'(stall), 0);
    chk("rstm_rw",    32'(rw_o), 0);
    chk("rstm_m2r",   32'(m2r_o), 0);
    chk("rstm_alu",   alu_o, 0);
    chk("rstm_scnt",  32'(scnt), 0);
    rvalid = 1; rdata = 32'hAAAA5555;
    step();
    rst = 1; ex_valid = 0; mem_read = 0; mem_to_reg = 0; reg_write = 0;
    #1;
    chk("stale_stall", 32'(stall), 0);
    step();
    #1;
    chk("stale_stall2", 32'(stall), 0);
    chk("stale_rdata",  rdata_o, 0);
    chk("stale_scnt",   32'(scnt), 0);
    clr_in();

    // Grant withheld 20 cycles: narrow counter saturates, wide one keeps counting
    ex_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu = 32'h400; reg_dst = 5'd6;
    req_hold = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req && stall) req_hold++;
      step();
    end
    chk("sat_req_hold", 32'(req_hold), 20);
    chk("sat_scnt4",    32'(scnt4), 32'hF);
    chk("sat_scnt16",   32'(scnt), 20);
    gnt = 1;
    #1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'hCAFEF00D;
    #1;
    step();
    rvalid = 0;
    #1;
    chk("sat_done_rdata", rdata_o, 32'hCAFEF00D);
    chk("sat_done_rw",    32'(rw_o), 1);
    chk("sat_scnt4_hold", 32'(scnt4), 32'hF);
    chk("sat_scnt16_end", 32'(scnt), 22);
    step();
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
